// File: rtl/day_schedule_fsm.sv
// Daily activity sequencer: SLEEP -> CLASS -> STUDY -> MEETING -> SLEEP with
// programmable dwell times, a saturating fatigue accumulator and a day counter.
//
// state   | meaning
// --------+---------------------------------------------------------------
// SLEEP   | resting; fatigue drains, wake accepted once the rest timer expires
// CLASS   | active; exits to MEETING instead of STUDY when already tired
// STUDY   | active; always followed by MEETING
// MEETING | active; exit closes the day and bumps day_cnt
module day_schedule_fsm #(
  parameter int CNT_W     = 8,
  parameter int SLEEP_CYC = 8,
  parameter int CLASS_CYC = 4,
  parameter int STUDY_CYC = 6,
  parameter int MEET_CYC  = 2,
  parameter int FAT_W     = 4,
  parameter int TIRED_TH  = 10,
  parameter int DAY_W     = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             wake,
  input  logic             hold,
  input  logic             skip,
  output logic [1:0]       state,
  output logic             home,
  output logic             tired,
  output logic [FAT_W-1:0] fatigue,
  output logic [DAY_W-1:0] day_cnt
);

  typedef enum logic [1:0] {
    SLEEP   = 2'b00,
    CLASS   = 2'b01,
    STUDY   = 2'b10,
    MEETING = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] SLEEP_LD = CNT_W'(SLEEP_CYC - 1);
  localparam logic [CNT_W-1:0] CLASS_LD = CNT_W'(CLASS_CYC - 1);
  localparam logic [CNT_W-1:0] STUDY_LD = CNT_W'(STUDY_CYC - 1);
  localparam logic [CNT_W-1:0] MEET_LD  = CNT_W'(MEET_CYC - 1);
  localparam logic [FAT_W-1:0] FAT_MAX  = '1;
  localparam logic [FAT_W-1:0] TH       = FAT_W'(TIRED_TH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [FAT_W-1:0] fatigue_d, fat_inc, fat_dec;
  logic [DAY_W-1:0] day_d;

  // Dwell is kept as cycles remaining in the state; zero means the state's
  // time is up (or, in SLEEP, that the rest period is complete).
  function automatic logic [CNT_W-1:0] load_of(state_t s);
    case (s)
      SLEEP:   return SLEEP_LD;
      CLASS:   return CLASS_LD;
      STUDY:   return STUDY_LD;
      default: return MEET_LD;
    endcase
  endfunction

  assign fat_inc = (fatigue == FAT_MAX) ? fatigue : fatigue + 1'b1;
  assign fat_dec = (fatigue == '0) ? fatigue : fatigue - 1'b1;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= SLEEP;
      remain_q <= '0;
      fatigue  <= '0;
      day_cnt  <= '0;
      home     <= 1'b1;
      tired    <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      fatigue  <= fatigue_d;
      day_cnt  <= day_d;
      home     <= (state_d == SLEEP);
      tired    <= (fatigue_d >= TH);
    end
  end

  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    fatigue_d = fatigue;
    day_d     = day_cnt;
    if (state_q == SLEEP) begin
      fatigue_d = fat_dec;
      if (remain_q != '0) begin
        remain_d = remain_q - 1'b1;
      end else if (wake) begin
        state_d  = CLASS;
        remain_d = load_of(CLASS);
      end
    end else if (skip || !hold) begin
      fatigue_d = fat_inc;
      if (skip || remain_q == '0) begin
        case (state_q)
          CLASS:   state_d = (fat_inc >= TH) ? MEETING : STUDY;
          STUDY:   state_d = MEETING;
          default: begin
            state_d = SLEEP;
            day_d   = day_cnt + 1'b1;
          end
        endcase
        remain_d = load_of(state_d);
      end else begin
        remain_d = remain_q - 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_day_schedule_fsm.sv
// Bench for day_schedule_fsm: three parameterisations driven by directed
// stimulus, checked every cycle against a schedule model plus literal points.
module tb_day_schedule_fsm;

  typedef struct packed {
    int sl; int cl; int st; int mt; int fmax; int th; int dmod;
  } prm_t;

  typedef struct packed {
    int st; int el; int fat; int day;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst_;
  logic [2:0] wake, hold, skip;

  logic [1:0] s0, s1, s2;
  logic [2:0] home_o, tired_o;
  logic [3:0] fat0, fat1;
  logic [2:0] fat2;
  logic [7:0] day0, day1;
  logic [1:0] day2;

  int a_st [3];
  int a_home [3];
  int a_tired [3];
  int a_fat [3];
  int a_day [3];

  int total = 0;
  int bad = 0;

  mdl_t m [3];

  always #5 clk = ~clk;

  day_schedule_fsm u0 (
    .clk(clk), .rst_(rst_), .wake(wake[0]), .hold(hold[0]), .skip(skip[0]),
    .state(s0), .home(home_o[0]), .tired(tired_o[0]), .fatigue(fat0), .day_cnt(day0)
  );

  day_schedule_fsm #(.TIRED_TH(4)) u1 (
    .clk(clk), .rst_(rst_), .wake(wake[1]), .hold(hold[1]), .skip(skip[1]),
    .state(s1), .home(home_o[1]), .tired(tired_o[1]), .fatigue(fat1), .day_cnt(day1)
  );

  day_schedule_fsm #(.DAY_W(2), .FAT_W(3), .TIRED_TH(6)) u2 (
    .clk(clk), .rst_(rst_), .wake(wake[2]), .hold(hold[2]), .skip(skip[2]),
    .state(s2), .home(home_o[2]), .tired(tired_o[2]), .fatigue(fat2), .day_cnt(day2)
  );

  assign a_st[0] = int'(s0);
  assign a_st[1] = int'(s1);
  assign a_st[2] = int'(s2);
  assign a_home[0] = int'(home_o[0]);
  assign a_home[1] = int'(home_o[1]);
  assign a_home[2] = int'(home_o[2]);
  assign a_tired[0] = int'(tired_o[0]);
  assign a_tired[1] = int'(tired_o[1]);
  assign a_tired[2] = int'(tired_o[2]);
  assign a_fat[0] = int'(fat0);
  assign a_fat[1] = int'(fat1);
  assign a_fat[2] = int'(fat2);
  assign a_day[0] = int'(day0);
  assign a_day[1] = int'(day1);
  assign a_day[2] = int'(day2);

  function automatic prm_t prm(int i);
    prm_t p;
    p.sl = 8; p.cl = 4; p.st = 6; p.mt = 2; p.fmax = 15; p.th = 10; p.dmod = 256;
    if (i == 1) p.th = 4;
    if (i == 2) begin
      p.fmax = 7; p.th = 6; p.dmod = 4;
    end
    return p;
  endfunction

  function automatic mdl_t mreset(prm_t p);
    mdl_t r;
    r.st = 0; r.el = p.sl - 1; r.fat = 0; r.day = 0;
    return r;
  endfunction

  // el = cycles already spent in the current state (hold cycles excluded)
  function automatic mdl_t step(mdl_t cur, prm_t p, logic w, logic h, logic s);
    mdl_t r;
    int dur;
    r = cur;
    if (cur.st == 0) begin
      r.fat = (cur.fat > 0) ? cur.fat - 1 : 0;
      if (w && cur.el >= p.sl - 1) begin
        r.st = 1;
        r.el = 0;
      end else begin
        r.el = (cur.el + 1 > p.sl - 1) ? p.sl - 1 : cur.el + 1;
      end
    end else if (s || !h) begin
      r.fat = (cur.fat < p.fmax) ? cur.fat + 1 : p.fmax;
      dur = (cur.st == 1) ? p.cl : (cur.st == 2) ? p.st : p.mt;
      if (s || cur.el + 1 >= dur) begin
        r.el = 0;
        case (cur.st)
          1: r.st = (r.fat >= p.th) ? 3 : 2;
          2: r.st = 3;
          default: begin
            r.st = 0;
            r.day = (cur.day + 1) % p.dmod;
          end
        endcase
      end else begin
        r.el = cur.el + 1;
      end
    end
    return r;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_) m[i] <= mreset(prm(i));
      else       m[i] <= step(m[i], prm(i), wake[i], hold[i], skip[i]);
    end
  end

  always @(negedge clk) begin
    if (rst_) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d_state", i), a_st[i], m[i].st);
        chk($sformatf("u%0d_home", i), a_home[i], (m[i].st == 0) ? 1 : 0);
        chk($sformatf("u%0d_tired", i), a_tired[i], (m[i].fat >= prm(i).th) ? 1 : 0);
        chk($sformatf("u%0d_fatigue", i), a_fat[i], m[i].fat);
        chk($sformatf("u%0d_day", i), a_day[i], m[i].day);
      end
    end
  end

  task automatic rst_pulse();
    wake = '0; hold = '0; skip = '0;
    @(negedge clk) rst_ = 1'b0;
    @(negedge clk) rst_ = 1'b1;
  endtask

  initial begin
    wake = '0; hold = '0; skip = '0;
    rst_ = 1'b1;
    #1 rst_ = 1'b0;
    #2;
    chk("rst_state", a_st[0], 0);
    chk("rst_home", a_home[0], 1);
    chk("rst_tired", a_tired[0], 0);
    chk("rst_fatigue", a_fat[0], 0);
    chk("rst_day", a_day[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst_ = 1'b1;
    wake[0] = 1'b1;

    // full day with wake held, then the rest period and the next CLASS
    for (int n = 1; n <= 31; n++) begin
      @(negedge clk);
      case (n)
        1:  begin chk("d1_n1_state", a_st[0], 1); chk("d1_n1_home", a_home[0], 0);
                  chk("d1_n1_fat", a_fat[0], 0); end
        4:  chk("d1_n4_state", a_st[0], 1);
        5:  begin chk("d1_n5_state", a_st[0], 2); chk("d1_n5_fat", a_fat[0], 4); end
        10: begin chk("d1_n10_state", a_st[0], 2); chk("d1_n10_fat", a_fat[0], 9);
                  chk("d1_n10_tired", a_tired[0], 0); end
        11: begin chk("d1_n11_state", a_st[0], 3); chk("d1_n11_fat", a_fat[0], 10);
                  chk("d1_n11_tired", a_tired[0], 1); end
        13: begin chk("d1_n13_state", a_st[0], 0); chk("d1_n13_home", a_home[0], 1);
                  chk("d1_n13_fat", a_fat[0], 12); chk("d1_n13_day", a_day[0], 1); end
        15: begin chk("sl_n15_fat", a_fat[0], 10); chk("sl_n15_tired", a_tired[0], 1); end
        16: begin chk("sl_n16_fat", a_fat[0], 9); chk("sl_n16_tired", a_tired[0], 0); end
        20: begin chk("sl_n20_state", a_st[0], 0); chk("sl_n20_fat", a_fat[0], 5); end
        21: begin chk("sl_n21_state", a_st[0], 1); chk("sl_n21_fat", a_fat[0], 4);
                  wake[0] = 1'b0; end
        25: begin chk("d2_n25_state", a_st[0], 2); chk("d2_n25_fat", a_fat[0], 8); end
        31: begin chk("d2_n31_state", a_st[0], 3); chk("d2_n31_fat", a_fat[0], 14);
                  chk("d2_n31_day", a_day[0], 1); end
        default: ;
      endcase
    end

    // asynchronous abort in MEETING, between clock edges
    #2 rst_ = 1'b0;
    #1;
    chk("abort_state", a_st[0], 0);
    chk("abort_home", a_home[0], 1);
    chk("abort_tired", a_tired[0], 0);
    chk("abort_fat", a_fat[0], 0);
    chk("abort_day", a_day[0], 0);
    #1 rst_ = 1'b1;
    wake[0] = 1'b1;
    @(negedge clk);
    chk("abort_wake_state", a_st[0], 1);
    chk("abort_wake_day", a_day[0], 0);
    wake[0] = 1'b0;

    // low tired threshold: CLASS goes straight to MEETING
    rst_pulse();
    wake[1] = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      case (n)
        1: chk("th4_n1_state", a_st[1], 1);
        4: begin chk("th4_n4_state", a_st[1], 1); chk("th4_n4_fat", a_fat[1], 3);
                 chk("th4_n4_tired", a_tired[1], 0); end
        5: begin chk("th4_n5_state", a_st[1], 3); chk("th4_n5_fat", a_fat[1], 4);
                 chk("th4_n5_tired", a_tired[1], 1); end
        6: begin chk("th4_n6_state", a_st[1], 3); chk("th4_n6_fat", a_fat[1], 5); end
        7: begin chk("th4_n7_state", a_st[1], 0); chk("th4_n7_day", a_day[1], 1);
                 chk("th4_n7_fat", a_fat[1], 6); end
        default: ;
      endcase
    end
    wake[1] = 1'b0;

    // hold for 5 cycles in STUDY
    rst_pulse();
    wake[0] = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      case (n)
        1:  begin chk("hold_n1_state", a_st[0], 1); wake[0] = 1'b0; end
        5:  begin chk("hold_n5_state", a_st[0], 2); chk("hold_n5_fat", a_fat[0], 4); end
        7:  begin chk("hold_n7_fat", a_fat[0], 6); hold[0] = 1'b1; end
        12: begin chk("hold_n12_state", a_st[0], 2); chk("hold_n12_fat", a_fat[0], 6);
                  hold[0] = 1'b0; end
        15: begin chk("hold_n15_state", a_st[0], 2); chk("hold_n15_fat", a_fat[0], 9); end
        16: begin chk("hold_n16_state", a_st[0], 3); chk("hold_n16_fat", a_fat[0], 10);
                  chk("hold_n16_tired", a_tired[0], 1); end
        default: ;
      endcase
    end

    // skip wins over hold in the first CLASS cycle
    rst_pulse();
    wake[0] = 1'b1;
    @(negedge clk);
    chk("skip_n1_state", a_st[0], 1);
    chk("skip_n1_fat", a_fat[0], 0);
    wake[0] = 1'b0; hold[0] = 1'b1; skip[0] = 1'b1;
    @(negedge clk);
    chk("skip_n2_state", a_st[0], 2);
    chk("skip_n2_fat", a_fat[0], 1);
    hold[0] = 1'b0; skip[0] = 1'b0;
    @(negedge clk);
    chk("skip_n3_state", a_st[0], 2);
    chk("skip_n3_fat", a_fat[0], 2);

    // narrow counters: four days wrap day_cnt, fatigue saturates at 7
    rst_pulse();
    wake[2] = 1'b1;
    for (int n = 1; n <= 73; n++) begin
      @(negedge clk);
      case (n)
        5:  begin chk("nw_n5_state", a_st[2], 2); chk("nw_n5_fat", a_fat[2], 4); end
        10: chk("nw_n10_fat", a_fat[2], 7);
        12: begin chk("nw_n12_state", a_st[2], 3); chk("nw_n12_fat", a_fat[2], 7); end
        13: begin chk("nw_n13_state", a_st[2], 0); chk("nw_n13_day", a_day[2], 1);
                  chk("nw_n13_fat", a_fat[2], 7); end
        21: begin chk("nw_n21_state", a_st[2], 1); chk("nw_n21_fat", a_fat[2], 0); end
        33: chk("nw_n33_day", a_day[2], 2);
        53: chk("nw_n53_day", a_day[2], 3);
        73: begin chk("nw_n73_day", a_day[2], 0); chk("nw_n73_state", a_st[2], 0); end
        default: ;
      endcase
    end
    wake[2] = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
